// File: rtl/exp_coeff_loader_pkg.sv
// Shared constants and state encoding for the exp coefficient loader.
// Word layout: base in the upper half, offset in the lower half.
package exp_coeff_loader_pkg;

    localparam int NUM_SEG     = 13;
    localparam int NUM_ENTRIES = 2 * NUM_SEG;

    localparam int BASE_MSB = 31;
    localparam int BASE_LSB = 16;
    localparam int OFF_MSB  = 15;
    localparam int OFF_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/exp_coeff_loader.sv
// Streams 2*NUM_SEG BF16 exp coefficient pairs into the exp unit config port,
// then checks a trailing XOR checksum word.
module exp_coeff_loader
    import exp_coeff_loader_pkg::*;
#(
    parameter int NUM_SEG = exp_coeff_loader_pkg::NUM_SEG,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             cfg_w_en,
    output logic             cfg_sgn,
    output logic [IDX_W-1:0] cfg_idx,
    output logic [15:0]      cfg_base,
    output logic [15:0]      cfg_offset,
    output logic             busy,
    output logic             done,
    output logic             crc_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    state_e             r_state;
    logic               r_sgn;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_acc;
    logic               r_cfg_w_en;
    logic               r_cfg_sgn;
    logic [IDX_W-1:0]   r_cfg_idx;
    logic [15:0]        r_cfg_base;
    logic [15:0]        r_cfg_offset;
    logic               r_done;
    logic               r_crc_err;

    logic               w_busy;
    logic               w_beat;
    logic               w_payload_beat;
    logic               w_check_beat;

    // abort drops ready combinationally so a coincident valid never forms a beat
    assign w_busy         = (r_state != ST_IDLE);
    assign in_ready       = w_busy & ~abort;
    assign w_beat         = in_valid & in_ready;
    assign w_payload_beat = w_beat & (r_state == ST_LOAD);
    assign w_check_beat   = w_beat & (r_state == ST_CHECK);

    // Sequencer: state, sign/index counters, checksum accumulator and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sgn     <= 1'b0;
            r_idx     <= '0;
            r_acc     <= 32'h0000_0000;
            r_done    <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_LOAD;
                        r_sgn     <= 1'b0;
                        r_idx     <= '0;
                        r_acc     <= 32'h0000_0000;
                        r_crc_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_payload_beat) begin
                        r_acc <= r_acc ^ in_data;
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            r_sgn <= 1'b1;
                            if (r_sgn) begin
                                r_state <= ST_CHECK;
                            end
                        end else begin
                            r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_check_beat) begin
                        r_crc_err <= (in_data != r_acc);
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Config write stage: fields hold their last written values between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_w_en   <= 1'b0;
            r_cfg_sgn    <= 1'b0;
            r_cfg_idx    <= '0;
            r_cfg_base   <= 16'h0000;
            r_cfg_offset <= 16'h0000;
        end else begin
            r_cfg_w_en <= w_payload_beat;
            if (w_payload_beat) begin
                r_cfg_sgn    <= r_sgn;
                r_cfg_idx    <= r_idx;
                r_cfg_base   <= in_data[BASE_MSB:BASE_LSB];
                r_cfg_offset <= in_data[OFF_MSB:OFF_LSB];
            end
        end
    end

    assign cfg_w_en   = r_cfg_w_en;
    assign cfg_sgn    = r_cfg_sgn;
    assign cfg_idx    = r_cfg_idx;
    assign cfg_base   = r_cfg_base;
    assign cfg_offset = r_cfg_offset;
    assign busy       = w_busy;
    assign done       = r_done;
    assign crc_err    = r_crc_err;

endmodule
